// File: rtl/attn_weighted_sum.sv
// Attention weighted sum: O[c] = sum_j P[j]*V[j][c], one V row per cycle with DIM
// parallel MACs, then round-half-up and saturate back to the input format.
module attn_weighted_sum #(
    parameter int D_W = 8,
    parameter int NUM = 4,
    parameter int DIM = 4
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic           I_START,
    input  logic [D_W-1:0] I_DATA [0:NUM-1],
    input  logic [D_W-1:0] I_V    [0:NUM*DIM-1],
    output logic           O_BUSY,
    output logic           O_VLD,
    output logic [D_W-1:0] O_DATA [0:DIM-1],
    output logic [1:0]     O_DBG_STATE
);

    localparam int FRAC = D_W - 3;
    localparam int PW   = 2 * D_W;
    localparam int CW   = $clog2(NUM);
    localparam int AW   = PW + CW;

    localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (D_W - 1) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);
    localparam logic signed [AW-1:0] RND     = AW'(2 ** (FRAC - 1));
    localparam logic [CW-1:0]        LAST    = CW'(NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, next_state;

    logic                  start_q;
    logic                  start_rise;
    logic [CW-1:0]         cnt;
    logic [D_W-1:0]        p_reg   [0:NUM-1];
    logic [D_W-1:0]        v_reg   [0:NUM-1][0:DIM-1];
    logic signed [AW-1:0]  acc     [0:DIM-1];
    logic signed [PW-1:0]  prod    [0:DIM-1];
    logic signed [AW-1:0]  acc_nxt [0:DIM-1];
    logic signed [AW-1:0]  rnd     [0:DIM-1];
    logic signed [AW-1:0]  shifted [0:DIM-1];
    logic [D_W-1:0]        res     [0:DIM-1];

    // Start handshake: a computation is launched by a 0->1 transition of I_START
    // seen in IDLE; rises while busy are dropped, never queued. O_VLD is a
    // single-cycle strobe and O_DATA holds its value until the next strobe.
    assign start_rise  = I_START & ~start_q;
    assign O_BUSY      = (state != IDLE);
    assign O_DBG_STATE = state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_rise) next_state = MAC;
            MAC:     if (cnt == LAST) next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            prod[c]    = $signed(p_reg[cnt]) * $signed(v_reg[cnt][c]);
            acc_nxt[c] = acc[c] + {{CW{prod[c][PW-1]}}, prod[c]};
            rnd[c]     = acc[c] + RND;
            shifted[c] = rnd[c] >>> FRAC;
            if (shifted[c] > SAT_MAX) begin
                res[c] = SAT_MAX[D_W-1:0];
            end else if (shifted[c] < SAT_MIN) begin
                res[c] = SAT_MIN[D_W-1:0];
            end else begin
                res[c] = shifted[c][D_W-1:0];
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state   <= IDLE;
            start_q <= 1'b0;
            cnt     <= '0;
            O_VLD   <= 1'b0;
            for (int j = 0; j < NUM; j++) begin
                p_reg[j] <= '0;
                for (int c = 0; c < DIM; c++) v_reg[j][c] <= '0;
            end
            for (int c = 0; c < DIM; c++) begin
                acc[c]    <= '0;
                O_DATA[c] <= '0;
            end
        end else begin
            start_q <= I_START;
            state   <= next_state;
            O_VLD   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rise) begin
                        cnt <= '0;
                        for (int j = 0; j < NUM; j++) begin
                            p_reg[j] <= I_DATA[j];
                            for (int c = 0; c < DIM; c++) v_reg[j][c] <= I_V[j*DIM + c];
                        end
                        for (int c = 0; c < DIM; c++) acc[c] <= '0;
                    end
                end
                MAC: begin
                    for (int c = 0; c < DIM; c++) acc[c] <= acc_nxt[c];
                    if (cnt != LAST) cnt <= cnt + CW'(1);
                end
                OUT: begin
                    for (int c = 0; c < DIM; c++) O_DATA[c] <= res[c];
                    O_VLD <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_weighted_sum.sv
// Directed bench for attn_weighted_sum (D_W=8, NUM=4, DIM=4): table-driven result
// checks plus hand-written start-handshake and mid-run reset sequences.
module tb_attn_weighted_sum;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] i_data [0:3];
    logic [7:0] i_v    [0:15];
    logic       busy;
    logic       vld;
    logic [7:0] o_data [0:3];
    logic [1:0] dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0]  p;
        logic [127:0] v;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [5];

    attn_weighted_sum #(.D_W(8), .NUM(4), .DIM(4)) dut (
        .I_CLK       (clk),
        .I_RST_N     (rst_n),
        .I_START     (start),
        .I_DATA      (i_data),
        .I_V         (i_v),
        .O_BUSY      (busy),
        .O_VLD       (vld),
        .O_DATA      (o_data),
        .O_DBG_STATE (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_pk();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = o_data[i];
        return r;
    endfunction

    task automatic set_inputs(input logic [31:0] p, input logic [127:0] v);
        for (int i = 0; i < 4; i++) i_data[i] = p[i*8 +: 8];
        for (int i = 0; i < 16; i++) i_v[i] = v[i*8 +: 8];
    endtask

    // Raise I_START at a negedge; returns at the negedge after the sampling edge (k=0).
    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
    endtask

    // Sample outputs at negedges k=0..n-1, then apply scheduled input changes.
    task automatic observe(input int n, input int raise_k, input int drop_k, input int vchg_k,
                           output int first, output int last, output int pulses, output int busy_n);
        first = -1; last = -1; pulses = 0; busy_n = 0;
        for (int k = 0; k < n; k++) begin
            if (busy) busy_n++;
            if (vld) begin
                pulses++;
                if (first < 0) first = k;
                last = k;
            end
            if (k == drop_k)  start = 1'b0;
            if (k == raise_k) start = 1'b1;
            if (k == vchg_k)  for (int i = 0; i < 16; i++) i_v[i] = 8'h60;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int idx);
        int first, last, pulses, busy_n;
        set_inputs(vecs[idx].p, vecs[idx].v);
        launch();
        observe(12, -1, 0, -1, first, last, pulses, busy_n);
        check($sformatf("vec%0d_latency", idx), first, 5);
        check($sformatf("vec%0d_busy_cycles", idx), busy_n, 5);
        check($sformatf("vec%0d_pulses", idx), pulses, 1);
        check($sformatf("vec%0d_data", idx), out_pk(), vecs[idx].exp);
    endtask

    initial begin
        int first, last, pulses, busy_n;

        // uniform 0.25 x 1.0 -> 1.0
        vecs[0] = '{p: 32'h08080808, v: {16{8'h20}}, exp: 32'h20202020};
        // one-hot P[0]=1.0, row 0 passes through exactly
        vecs[1] = '{p: 32'h00000020, v: {$urandom, $urandom, $urandom, 32'hF0117F80}, exp: 32'hF0117F80};
        // 4 x 1.0 x 3.0 = 12.0 -> positive clamp
        vecs[2] = '{p: 32'h20202020, v: {16{8'h60}}, exp: 32'h7F7F7F7F};
        // 4 x 1.0 x -3.0 = -12.0 -> negative clamp
        vecs[3] = '{p: 32'h20202020, v: {16{8'hA0}}, exp: 32'h80808080};
        // 1/32 x {0.5, 15/32, -0.5, 0}: half rounds up, below half and -half go to 0
        vecs[4] = '{p: 32'h00000001, v: {$urandom, $urandom, $urandom, 32'h00F00F10}, exp: 32'h00000001};

        rst_n = 1'b0;
        start = 1'b0;
        set_inputs(32'h0, 128'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_vld", vld, 0);
        check("reset_data", out_pk(), 0);
        check("reset_state", dbg_state, 0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // mixed weights: 0.5*1 + 0.25*2 + 0.125*-1 + 0.125*0.5 = 0.9375 -> 0x1E
        set_inputs(32'h04040810, {32'h10101010, 32'hE0E0E0E0, 32'h40404040, 32'h20202020});
        launch();
        observe(12, -1, 0, -1, first, last, pulses, busy_n);
        check("mixed_data", out_pk(), 32'h1E1E1E1E);

        // held high 20 cycles, V overwritten during MAC: one pulse, original result
        set_inputs(32'h08080808, {16{8'h20}});
        launch();
        observe(24, -1, 20, 2, first, last, pulses, busy_n);
        check("held_pulses", pulses, 1);
        check("held_latency", first, 5);
        check("held_data", out_pk(), 32'h20202020);

        // drop then re-raise during MAC: ignored
        set_inputs(32'h20202020, {16{8'h60}});
        launch();
        observe(16, 2, 0, -1, first, last, pulses, busy_n);
        check("reraise_mac_pulses", pulses, 1);
        check("reraise_mac_data", out_pk(), 32'h7F7F7F7F);
        start = 1'b0;

        // rise in the first IDLE cycle is accepted: second result 6 edges after the first
        set_inputs(32'h20202020, {16{8'hA0}});
        launch();
        observe(16, 5, 0, -1, first, last, pulses, busy_n);
        check("back2back_pulses", pulses, 2);
        check("back2back_first", first, 5);
        check("back2back_second", last, 11);
        check("back2back_busy", busy_n, 10);
        check("back2back_data", out_pk(), 32'h80808080);
        start = 1'b0;

        // reset at MAC row 2: no result for the aborted run
        set_inputs(32'h08080808, {16{8'h20}});
        launch();
        observe(2, -1, 0, -1, first, last, pulses, busy_n);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy", busy, 0);
        check("midrst_vld", vld, 0);
        check("midrst_data", out_pk(), 0);
        observe(10, -1, -1, -1, first, last, pulses, busy_n);
        check("midrst_no_pulse", pulses, 0);
        run_vec(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
